// File: rtl/approx_mult_pkg.sv
// Shared types and helpers for the pipelined approximate multiplier.
// Mode encoding, stage payload and partial-product column geometry.
package approx_mult_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // Widest tag a stage payload can carry; TAG_W must not exceed it.
    localparam int TAG_MAX = 16;

    typedef struct packed {
        logic               valid;
        logic [TAG_MAX-1:0] tag;
        logic               mode;
    } stage_t;

    // Number of partial-product bits landing in column k of a w x w product.
    function automatic int col_height(input int w, input int k);
        int h;
        if (k < 0 || k > 2*w - 2) begin
            h = 0;
        end else if (k < w) begin
            h = k + 1;
        end else begin
            h = 2*w - 1 - k;
        end
        return h;
    endfunction

endpackage

// File: rtl/approx_42_cell.sv
// Approximate 4:2 compressor: lossy carry/sum pair for one group of
// four same-weight bits; never over-estimates the group's popcount.
module approx_42_cell (
    input  logic w,
    input  logic x,
    input  logic y,
    input  logic z,
    output logic sum,
    output logic carry
);

    assign carry = (w & x) | (y & z);
    assign sum   = (w ^ x) | (y ^ z);

endmodule

// File: rtl/approx_mult_pipe.sv
// Three-stage unsigned W x W multiplier with selectable approximate
// compression of the low product columns and valid/ready streaming.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int W           = 16,
    parameter int APPROX_COLS = 16,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_p,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_mode
);

    localparam int PW = 2 * W;
    localparam int CW = $clog2(W + 1);

    stage_t s1, s2, s3;

    logic [PW-1:0][CW-1:0] col_nx, col_q;
    logic [PW-1:0] row0_nx, row1_nx;
    logic [PW-1:0] row0_q, row1_q;
    logic [PW-1:0] p_q;
    logic s1_en, s2_en, s3_en;
    logic unused_tag_hi;

    // A stage may load when empty or when its occupant leaves this cycle.
    assign s3_en    = !s3.valid | out_ready;
    assign s2_en    = !s2.valid | s3_en;
    assign s1_en    = !s1.valid | s2_en;
    assign in_ready = s1_en;

    for (genvar k = 0; k < PW; k++) begin : g_col
        localparam int H    = col_height(W, k);
        localparam int IMIN = (k >= W) ? k - W + 1 : 0;
        localparam int NG   = H / 4;

        if (H == 0) begin : g_empty
            assign col_nx[k] = '0;
        end else begin : g_live
            logic [H-1:0]         bits;
            logic [NG:0][CW-1:0]  acc;
            logic [CW-1:0]        left;

            // Bits ordered by ascending multiplier row i.
            for (genvar n = 0; n < H; n++) begin : g_pp
                assign bits[n] = in_a[k-IMIN-n] & in_b[IMIN+n];
            end

            always_comb begin
                left = '0;
                for (int n = 4 * NG; n < H; n++) begin
                    left = left + CW'(bits[n]);
                end
            end

            assign acc[0] = left;

            for (genvar g = 0; g < NG; g++) begin : g_grp
                logic [3:0] q;
                logic [2:0] ex;
                logic [2:0] gv;

                assign q  = bits[4*g +: 4];
                assign ex = {2'b00, q[0]} + {2'b00, q[1]}
                          + {2'b00, q[2]} + {2'b00, q[3]};

                if (k < APPROX_COLS) begin : g_apx
                    logic s, c;

                    approx_42_cell u_cell (
                        .w     (q[0]),
                        .x     (q[1]),
                        .y     (q[2]),
                        .z     (q[3]),
                        .sum   (s),
                        .carry (c)
                    );

                    assign gv = (in_mode == MODE_APPROX) ? {1'b0, c, s} : ex;
                end else begin : g_ex
                    assign gv = ex;
                end

                assign acc[g+1] = acc[g] + CW'(gv);
            end

            assign col_nx[k] = acc[NG];
        end
    end

    // Even and odd columns never share a weight, so each forms one row.
    always_comb begin
        row0_nx = '0;
        row1_nx = '0;
        for (int k = 0; k < PW; k++) begin
            if ((k % 2) != 0) begin
                row1_nx = row1_nx + (PW'(col_q[k]) << k);
            end else begin
                row0_nx = row0_nx + (PW'(col_q[k]) << k);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= '0;
            col_q <= '0;
        end else if (s1_en) begin
            s1.valid <= in_valid;
            if (in_valid) begin
                s1.tag  <= TAG_MAX'(in_tag);
                s1.mode <= in_mode;
                col_q   <= col_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2     <= '0;
            row0_q <= '0;
            row1_q <= '0;
        end else if (s2_en) begin
            s2.valid <= s1.valid;
            if (s1.valid) begin
                s2.tag  <= s1.tag;
                s2.mode <= s1.mode;
                row0_q  <= row0_nx;
                row1_q  <= row1_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3  <= '0;
            p_q <= '0;
        end else if (s3_en) begin
            s3.valid <= s2.valid;
            if (s2.valid) begin
                s3.tag  <= s2.tag;
                s3.mode <= s2.mode;
                p_q     <= row0_q + row1_q;
            end
        end
    end

    assign out_valid     = s3.valid;
    assign out_p         = p_q;
    assign out_tag       = s3.tag[TAG_W-1:0];
    assign out_mode      = s3.mode;
    assign unused_tag_hi = ^(s3.tag >> TAG_W);

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Self-checking bench: vector table, random stream with scoreboard,
// backpressure fill, async reset flush and an always-exact build.
module tb_approx_mult_pipe;

    localparam int W  = 16;
    localparam int AC = 16;
    localparam int TW = 4;
    localparam int PW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic          in_mode = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid, out_mode;
    logic [PW-1:0] out_p;
    logic [TW-1:0] out_tag;
    logic          in_ready0, out_valid0, out_mode0;
    logic [PW-1:0] out_p0;
    logic [TW-1:0] out_tag0;

    typedef struct {
        logic [PW-1:0] p;
        logic [TW-1:0] tag;
        logic          mode;
    } exp_t;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic          m;
        logic [TW-1:0] t;
        logic [PW-1:0] p;
    } tv_t;

    exp_t q[$];
    exp_t q0[$];
    int   tests = 0;
    int   fails = 0;
    int   ready_mode = 1;

    approx_mult_pipe #(.W(W), .APPROX_COLS(AC), .TAG_W(TW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_p(out_p), .out_tag(out_tag), .out_mode(out_mode)
    );

    approx_mult_pipe #(.W(W), .APPROX_COLS(0), .TAG_W(TW)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready0),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_p(out_p0), .out_tag(out_tag0), .out_mode(out_mode0)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    // Consumer readiness: 0 = stalled, 1 = always ready, else random.
    initial forever begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] model(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic m, input int ac);
        logic [PW-1:0] acc;
        logic          bits [W];
        int            n, cv;
        acc = '0;
        for (int k = 0; k < PW - 1; k++) begin
            n  = 0;
            cv = 0;
            for (int i = 0; i < W; i++) begin
                if (k - i >= 0 && k - i < W) begin
                    bits[n] = a[k-i] & b[i];
                    n++;
                end
            end
            if (m && k < ac) begin
                for (int g = 0; g + 3 < n; g += 4) begin
                    cv += 2 * int'((bits[g] & bits[g+1]) | (bits[g+2] & bits[g+3]));
                    cv += int'((bits[g] ^ bits[g+1]) | (bits[g+2] ^ bits[g+3]));
                end
                for (int r = (n / 4) * 4; r < n; r++) cv += int'(bits[r]);
            end else begin
                for (int r = 0; r < n; r++) cv += int'(bits[r]);
            end
            acc = acc + (PW'(cv) << k);
        end
        return acc;
    endfunction

    // Scoreboard side: stall stability and in-order result comparison.
    logic hold_v = 1'b0;
    exp_t hold;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            q.delete();
            q0.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("stall_stable", {out_valid, out_p, out_tag, out_mode},
                      {1'b1, hold.p, hold.tag, hold.mode});
            end
            hold_v = out_valid && !out_ready;
            hold   = '{p: out_p, tag: out_tag, mode: out_mode};
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got p=%h, want no result", out_p);
                end else begin
                    e = q.pop_front();
                    check("result", {out_p, out_tag, out_mode}, {e.p, e.tag, e.mode});
                end
            end
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out0: got p=%h, want no result", out_p0);
                end else begin
                    e = q0.pop_front();
                    check("exact_build", {out_p0, out_tag0, out_mode0},
                          {e.p, e.tag, e.mode});
                end
            end
        end
    end

    // Called at a negedge: record whatever each instance accepts next edge.
    task automatic note_accept(input logic [PW-1:0] e, output bit acc);
        if (in_ready0) q0.push_back('{p: PW'(in_a) * PW'(in_b), tag: in_tag, mode: in_mode});
        acc = in_ready;
        if (in_ready) q.push_back('{p: e, tag: in_tag, mode: in_mode});
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic [TW-1:0] t,
                        input logic [PW-1:0] e);
        bit ok, acc;
        in_a = a; in_b = b; in_mode = m; in_tag = t; in_valid = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            note_accept(e, acc);
            ok = acc;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no in_ready, want acceptance");
        end
    endtask

    task automatic new_beat();
        in_a = W'($urandom);
        in_b = W'($urandom);
        in_mode = 1'($urandom_range(0, 1));
        in_tag = TW'($urandom);
        in_valid = 1'b1;
    endtask

    // Keep in_valid high for n cycles, replacing a beat only once accepted.
    task automatic stream(input int n, output int accepted);
        bit acc;
        accepted = 0;
        if (!in_valid) new_beat();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            note_accept(model(in_a, in_b, in_mode, AC), acc);
            @(posedge clk);
            #1;
            if (acc) begin
                accepted++;
                new_beat();
            end
        end
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && (q.size() > 0 || q0.size() > 0); c++) @(negedge clk);
        @(posedge clk);
        #1;
        check("drain", 64'(q.size() + q0.size()), 64'd0);
    endtask

    initial begin
        tv_t tv [8];
        int  acc_n, vcount;

        tv[0] = '{16'hFFFF, 16'hFFFF, 1'b1, 4'd5,  32'hFFF71111};
        tv[1] = '{16'hFFFF, 16'hFFFF, 1'b0, 4'd6,  32'hFFFE0001};
        tv[2] = '{16'h0003, 16'h0005, 1'b1, 4'd7,  32'h0000000F};
        tv[3] = '{16'h000F, 16'h000F, 1'b1, 4'd8,  32'h000000D1};
        tv[4] = '{16'h000F, 16'h000F, 1'b0, 4'd9,  32'h000000E1};
        tv[5] = '{16'h0001, 16'hFFFF, 1'b1, 4'd10, 32'h0000FFFF};
        tv[6] = '{16'hFFFF, 16'h0000, 1'b1, 4'd11, 32'h00000000};
        tv[7] = '{16'hFFFF, 16'h0001, 1'b1, 4'd12, 32'h0000FFFF};

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", {out_valid, out_p, out_tag, out_mode}, '0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", in_ready, 1'b1);

        send(tv[0].a, tv[0].b, tv[0].m, tv[0].t, tv[0].p);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_1", out_valid, 1'b0);
        @(negedge clk);
        check("latency_2", out_valid, 1'b0);
        @(negedge clk);
        check("latency_3", out_valid, 1'b1);
        drain();

        for (int i = 0; i < 8; i++) send(tv[i].a, tv[i].b, tv[i].m, tv[i].t, tv[i].p);
        in_valid = 1'b0;
        drain();

        ready_mode = 2;
        vcount = 0;
        while (vcount < 100) begin
            stream(1, acc_n);
            vcount += acc_n;
        end
        in_valid = 1'b0;
        ready_mode = 1;
        drain();

        ready_mode = 0;
        @(posedge clk);
        #1;
        stream(10, acc_n);
        check("bp_accepted", 64'(acc_n), 64'd3);
        check("bp_in_ready", in_ready, 1'b0);
        ready_mode = 1;
        stream(6, acc_n);
        check("bp_resume_rate", 64'(acc_n), 64'd6);
        in_valid = 1'b0;
        drain();

        send(16'h1234, 16'h5678, 1'b1, 4'd1, model(16'h1234, 16'h5678, 1'b1, AC));
        send(16'hABCD, 16'h00FF, 1'b0, 4'd2, model(16'hABCD, 16'h00FF, 1'b0, AC));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_pre_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_out", {out_valid, out_p, out_tag, out_mode}, '0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        acc_n = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid || out_valid0) acc_n++;
        end
        check("rst_no_stale", 64'(acc_n), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
